// File: rtl/aho_table_writer.sv
// -----------------------------------------------------------------------------
// aho_table_writer
//
// Loads the Aho-Corasick goto and failure tables that the table reader uses.
// Each session starts with START. The writer first clears every entry of both
// RAMs. It then accepts goto and failure entries over a valid/ready handshake
// until COMMIT. Goto entries are packed from address 0 in arrival order.
// Failure entries are written at address state-1.
//
// Optional feature (compile-time macro AHO_TW_DUP_CHECK_EN):
//   When the macro is defined, the writer keeps a shadow copy of every
//   {cur_state, chara} key written this session. A goto entry whose key is
//   already in the shadow is dropped and ERR_DUP is raised.
//   When the macro is undefined, duplicates are written like any other entry
//   and ERR_DUP is tied to 0.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   START, COMMIT     1-cycle pulses that open and close a load session
//   IN_VALID/IN_READY entry handshake; IN_KIND 0=goto, 1=failure
//   IN_CUR_STATE, IN_CHARA, IN_NEXT_STATE  entry fields
//   WR_EN_G, WR_ADDR_G, WR_CUR_STATE, WR_CHARA, WR_NEXT_STATE  goto RAM write
//   WR_EN_F, WR_ADDR_F, WR_FAIL_STATE                          failure RAM write
//   GOTO_COUNT        goto entries written this session
//   BUSY, DONE        session status
//   ERR_FULL, ERR_STATE, ERR_DUP  sticky drop flags, cleared by START
// -----------------------------------------------------------------------------
module aho_table_writer #(
  parameter int DEPTH   = 32,
  parameter int STATE_W = 8,
  parameter int CHARA_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic                     IN_KIND,
  input  logic [STATE_W-1:0]       IN_CUR_STATE,
  input  logic [CHARA_W-1:0]       IN_CHARA,
  input  logic [STATE_W-1:0]       IN_NEXT_STATE,
  input  logic                     COMMIT,
  output logic                     WR_EN_G,
  output logic [$clog2(DEPTH)-1:0] WR_ADDR_G,
  output logic [STATE_W-1:0]       WR_CUR_STATE,
  output logic [CHARA_W-1:0]       WR_CHARA,
  output logic [STATE_W-1:0]       WR_NEXT_STATE,
  output logic                     WR_EN_F,
  output logic [$clog2(DEPTH)-1:0] WR_ADDR_F,
  output logic [STATE_W-1:0]       WR_FAIL_STATE,
  output logic [$clog2(DEPTH):0]   GOTO_COUNT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR_FULL,
  output logic                     ERR_STATE,
  output logic                     ERR_DUP
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [STATE_W:0] DEPTH_S = (STATE_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] clr_addr;
  logic          clr_write;
  logic          xfer;
  logic          g_full;
  logic          g_dup;
  logic          g_write;
  logic          g_drop_full;
  logic          f_bad;
  logic          f_write;
  logic          f_drop;
  logic [AW-1:0] fail_addr;

  // Failure entries for states 1..DEPTH map to addresses 0..DEPTH-1.
  // Only the low address bits matter: state DEPTH has low bits 0, and
  // subtracting 1 wraps it to DEPTH-1.
  assign fail_addr = IN_CUR_STATE[AW-1:0] - AW'(1);

  assign IN_READY = (state == S_LOAD);
  assign BUSY     = (state == S_CLEAR) || (state == S_LOAD);
  assign DONE     = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // START has priority in every state. It abandons any session in progress,
  // so an entry that arrives on the same edge is discarded.
  always_comb begin
    state_nx    = state;
    clr_write   = 1'b0;
    xfer        = 1'b0;
    g_write     = 1'b0;
    g_drop_full = 1'b0;
    f_write     = 1'b0;
    f_drop      = 1'b0;
    g_full      = (GOTO_COUNT == CW'(DEPTH));
    f_bad       = (IN_CUR_STATE == '0) || ({1'b0, IN_CUR_STATE} > DEPTH_S);
    case (state)
      S_IDLE, S_DONE: begin
        if (START) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        if (START) begin
          state_nx = S_CLEAR;
        end else begin
          clr_write = 1'b1;
          if (clr_addr == AW'(DEPTH-1)) state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (START) begin
          state_nx = S_CLEAR;
        end else begin
          xfer = IN_VALID;
          if (COMMIT) state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (xfer && !IN_KIND) begin
      // A duplicate is reported as a duplicate even when the table is full.
      if (!g_dup) begin
        g_write     = !g_full;
        g_drop_full = g_full;
      end
    end
    if (xfer && IN_KIND) begin
      f_write = !f_bad;
      f_drop  = f_bad;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clr_addr <= '0;
    end else if (clr_write) begin
      clr_addr <= clr_addr + AW'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  // The write port is registered: each write appears one cycle after the
  // edge that accepted it. Clear writes carry all-zero data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WR_EN_G       <= 1'b0;
      WR_ADDR_G     <= '0;
      WR_CUR_STATE  <= '0;
      WR_CHARA      <= '0;
      WR_NEXT_STATE <= '0;
      WR_EN_F       <= 1'b0;
      WR_ADDR_F     <= '0;
      WR_FAIL_STATE <= '0;
    end else begin
      WR_EN_G <= clr_write || g_write;
      WR_EN_F <= clr_write || f_write;
      if (clr_write) begin
        WR_ADDR_G     <= clr_addr;
        WR_CUR_STATE  <= '0;
        WR_CHARA      <= '0;
        WR_NEXT_STATE <= '0;
        WR_ADDR_F     <= clr_addr;
        WR_FAIL_STATE <= '0;
      end else begin
        if (g_write) begin
          WR_ADDR_G     <= GOTO_COUNT[AW-1:0];
          WR_CUR_STATE  <= IN_CUR_STATE;
          WR_CHARA      <= IN_CHARA;
          WR_NEXT_STATE <= IN_NEXT_STATE;
        end
        if (f_write) begin
          WR_ADDR_F     <= fail_addr;
          WR_FAIL_STATE <= IN_NEXT_STATE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      GOTO_COUNT <= '0;
      ERR_FULL   <= 1'b0;
      ERR_STATE  <= 1'b0;
    end else if (START) begin
      GOTO_COUNT <= '0;
      ERR_FULL   <= 1'b0;
      ERR_STATE  <= 1'b0;
    end else begin
      if (g_write)     GOTO_COUNT <= GOTO_COUNT + CW'(1);
      if (g_drop_full) ERR_FULL   <= 1'b1;
      if (f_drop)      ERR_STATE  <= 1'b1;
    end
  end

`ifdef AHO_TW_DUP_CHECK_EN
  logic [STATE_W+CHARA_W-1:0] shadow_key [DEPTH];
  logic [DEPTH-1:0]           shadow_vld;

  always_comb begin
    g_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (shadow_vld[i] && (shadow_key[i] == {IN_CUR_STATE, IN_CHARA})) g_dup = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (g_write) shadow_key[GOTO_COUNT[AW-1:0]] <= {IN_CUR_STATE, IN_CHARA};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_vld <= '0;
      ERR_DUP    <= 1'b0;
    end else if (START || (state == S_CLEAR)) begin
      shadow_vld <= '0;
      if (START) ERR_DUP <= 1'b0;
    end else begin
      if (g_write) shadow_vld[GOTO_COUNT[AW-1:0]] <= 1'b1;
      if (xfer && !IN_KIND && g_dup) ERR_DUP <= 1'b1;
    end
  end
`else
  assign g_dup   = 1'b0;
  assign ERR_DUP = 1'b0;
`endif

endmodule

// File: tb/tb_aho_table_writer.sv
module tb_aho_table_writer;

  localparam int DEPTH = 32;
`ifdef AHO_TW_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       IN_KIND = 1'b0;
  logic [7:0] IN_CUR_STATE = '0;
  logic [3:0] IN_CHARA = '0;
  logic [7:0] IN_NEXT_STATE = '0;
  logic       COMMIT = 1'b0;
  logic       WR_EN_G;
  logic [4:0] WR_ADDR_G;
  logic [7:0] WR_CUR_STATE;
  logic [3:0] WR_CHARA;
  logic [7:0] WR_NEXT_STATE;
  logic       WR_EN_F;
  logic [4:0] WR_ADDR_F;
  logic [7:0] WR_FAIL_STATE;
  logic [5:0] GOTO_COUNT;
  logic       BUSY, DONE, ERR_FULL, ERR_STATE, ERR_DUP;

  aho_table_writer #(.DEPTH(DEPTH), .STATE_W(8), .CHARA_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IN_KIND(IN_KIND), .IN_CUR_STATE(IN_CUR_STATE),
    .IN_CHARA(IN_CHARA), .IN_NEXT_STATE(IN_NEXT_STATE), .COMMIT(COMMIT),
    .WR_EN_G(WR_EN_G), .WR_ADDR_G(WR_ADDR_G), .WR_CUR_STATE(WR_CUR_STATE),
    .WR_CHARA(WR_CHARA), .WR_NEXT_STATE(WR_NEXT_STATE), .WR_EN_F(WR_EN_F),
    .WR_ADDR_F(WR_ADDR_F), .WR_FAIL_STATE(WR_FAIL_STATE),
    .GOTO_COUNT(GOTO_COUNT), .BUSY(BUSY), .DONE(DONE), .ERR_FULL(ERR_FULL),
    .ERR_STATE(ERR_STATE), .ERR_DUP(ERR_DUP)
  );

  always #5 CLK = ~CLK;

  typedef struct {int addr; int cur; int ch; int nxt;} gexp_t;
  typedef struct {int addr; int data;} fexp_t;

  gexp_t gq[$];
  fexp_t fq[$];
  int    keys[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    m_count;
  bit    m_full, m_serr, m_dup;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops the oldest expected write.
  always @(negedge CLK) begin
    if (RST_N && WR_EN_G) begin
      if (gq.size() == 0) begin
        check("g_unexpected_write", 1, 0);
      end else begin
        gexp_t g;
        g = gq.pop_front();
        check("g_addr", int'(WR_ADDR_G), g.addr);
        check("g_cur", int'(WR_CUR_STATE), g.cur);
        check("g_chara", int'(WR_CHARA), g.ch);
        check("g_next", int'(WR_NEXT_STATE), g.nxt);
      end
    end
    if (RST_N && WR_EN_F) begin
      if (fq.size() == 0) begin
        check("f_unexpected_write", 1, 0);
      end else begin
        fexp_t f;
        f = fq.pop_front();
        check("f_addr", int'(WR_ADDR_F), f.addr);
        check("f_data", int'(WR_FAIL_STATE), f.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    int  n;
    bit  busy_ok;
    START = 1'b1;
    m_count = 0; m_full = 0; m_serr = 0; m_dup = 0;
    keys.delete();
    for (int i = 0; i < DEPTH; i++) begin
      gq.push_back('{addr: i, cur: 0, ch: 0, nxt: 0});
      fq.push_back('{addr: i, data: 0});
    end
    tick();
    START = 1'b0;
    check("start_count", int'(GOTO_COUNT), 0);
    check("start_err_full", int'(ERR_FULL), 0);
    check("start_err_state", int'(ERR_STATE), 0);
    check("start_err_dup", int'(ERR_DUP), 0);
    check("start_done", int'(DONE), 0);
    n = 0;
    busy_ok = 1'b1;
    while (!IN_READY && n < 200) begin
      if (!BUSY) busy_ok = 1'b0;
      tick();
      n++;
    end
    check("clear_len", n, DEPTH);
    check("clear_busy", int'(busy_ok), 1);
    check("load_busy", int'(BUSY), 1);
  endtask

  task automatic send(input bit kind, input int cur, input int ch, input int nxt,
                      input bit commit);
    IN_VALID = 1'b1;
    IN_KIND = kind;
    IN_CUR_STATE = 8'(cur);
    IN_CHARA = 4'(ch);
    IN_NEXT_STATE = 8'(nxt);
    COMMIT = commit;
    if (!kind) begin
      int key;
      bit seen;
      key = cur * 16 + ch;
      seen = 1'b0;
      foreach (keys[i]) if (keys[i] == key) seen = 1'b1;
      if (DUP_EN && seen) m_dup = 1'b1;
      else if (m_count == DEPTH) m_full = 1'b1;
      else begin
        gq.push_back('{addr: m_count, cur: cur, ch: ch, nxt: nxt});
        keys.push_back(key);
        m_count++;
      end
    end else begin
      if (cur == 0 || cur > DEPTH) m_serr = 1'b1;
      else fq.push_back('{addr: cur - 1, data: nxt});
    end
    tick();
    IN_VALID = 1'b0;
    COMMIT = 1'b0;
  endtask

  task automatic do_commit();
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  task automatic check_session();
    check("sess_count", int'(GOTO_COUNT), m_count);
    check("sess_done", int'(DONE), 1);
    check("sess_ready", int'(IN_READY), 0);
    check("sess_busy", int'(BUSY), 0);
    check("sess_err_full", int'(ERR_FULL), int'(m_full));
    check("sess_err_state", int'(ERR_STATE), int'(m_serr));
    check("sess_err_dup", int'(ERR_DUP), int'(m_dup));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_ready", int'(IN_READY), 0);
    check("rst_wr_en_g", int'(WR_EN_G), 0);
    check("rst_wr_en_f", int'(WR_EN_F), 0);
    check("rst_count", int'(GOTO_COUNT), 0);
    check("rst_err_full", int'(ERR_FULL), 0);
    check("rst_err_state", int'(ERR_STATE), 0);
    check("rst_err_dup", int'(ERR_DUP), 0);
    RST_N = 1'b1;
    tick();
    // Entries and COMMIT while idle are ignored.
    IN_VALID = 1'b1; COMMIT = 1'b1;
    tick();
    IN_VALID = 1'b0; COMMIT = 1'b0;
    check("idle_ready", int'(IN_READY), 0);
    check("idle_done", int'(DONE), 0);

    // Three goto entries, then commit.
    do_start();
    send(0, 0, 1, 1, 0);
    send(0, 1, 2, 2, 0);
    send(0, 0, 3, 3, 0);
    do_commit();
    check_session();
    // Traffic in DONE is ignored and writes nothing.
    IN_VALID = 1'b1; COMMIT = 1'b1;
    tick();
    IN_VALID = 1'b0; COMMIT = 1'b0;
    tick();
    check_session();

    // Failure entries: overwrite, state 0 and out-of-range state dropped.
    do_start();
    send(1, 5, 0, 2, 0);
    send(1, 5, 0, 0, 0);
    send(1, 0, 0, 4, 0);
    send(1, 33, 0, 1, 0);
    send(1, 32, 0, 7, 0);
    do_commit();
    check_session();

    // Fill the goto table and overflow by one.
    do_start();
    for (int i = 0; i < DEPTH + 1; i++) send(0, i + 1, i % 16, (i * 3) % 256, 0);
    do_commit();
    check_session();

    // Entry and COMMIT on the same edge.
    do_start();
    send(0, 4, 4, 4, 1);
    check_session();

    // START in the middle of a load abandons the session.
    do_start();
    for (int i = 0; i < 5; i++) send(0, i, 9, i + 10, 0);
    send(1, 0, 0, 1, 0);
    check("mid_err_state", int'(ERR_STATE), 1);
    check("mid_count", int'(GOTO_COUNT), 5);
    do_start();
    send(0, 6, 6, 6, 0);
    do_commit();
    check_session();

    // Duplicate goto entry.
    do_start();
    send(0, 2, 4, 5, 0);
    send(0, 2, 4, 5, 0);
    do_commit();
    check_session();

    repeat (3) tick();
    check("goto_left", gq.size(), 0);
    check("fail_left", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aho_table_writer.md
Name: aho_table_writer

Overview:
Builds the Aho-Corasick goto and failure tables consumed by the table reader. Accepts a stream of goto entries (current state, character, next state) and failure entries (state, failure state) over a valid/ready handshake. Writes them into the goto and failure RAMs at the addresses the reader indexes: the goto table is packed from address 0, and the failure table is indexed by state-1. Sits between the pattern-compiler host interface and the table RAMs; clears both RAMs before each load.

Parameters:
DEPTH, 32, entries per table RAM (goto and failure); power of two, at most 256
STATE_W, 8, state field width
CHARA_W, 4, character field width (matches the reader's RAM_CHARA width)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  1-cycle pulse; begin clear+load session
IN_VALID  in  1  entry valid
IN_READY  out  1  writer can accept entry
IN_KIND  in  1  0=goto entry, 1=failure entry
IN_CUR_STATE  in  STATE_W  goto current state / failure source state
IN_CHARA  in  CHARA_W  goto character (ignored for failure)
IN_NEXT_STATE  in  STATE_W  goto next state / failure target state
COMMIT  in  1  1-cycle pulse; end of load session
WR_EN_G  out  1  goto RAM write strobe (all three goto RAMs)
WR_ADDR_G  out  $clog2(DEPTH)  goto RAM address
WR_CUR_STATE  out  STATE_W  data for current-state RAM
WR_CHARA  out  CHARA_W  data for character RAM
WR_NEXT_STATE  out  STATE_W  data for next-state RAM
WR_EN_F  out  1  failure RAM write strobe
WR_ADDR_F  out  $clog2(DEPTH)  failure RAM address
WR_FAIL_STATE  out  STATE_W  failure RAM data
GOTO_COUNT  out  $clog2(DEPTH)+1  goto entries written this session
BUSY  out  1  high in CLEAR and LOAD
DONE  out  1  high in DONE state; tables valid for the reader
ERR_FULL  out  1  sticky; goto entry dropped because the table was full
ERR_STATE  out  1  sticky; failure entry with state 0 or state > DEPTH dropped
ERR_DUP  out  1  sticky; duplicate goto entry dropped (optional feature)

Behaviour:
- Reset (async, RST_N=0): state IDLE. All outputs 0, GOTO_COUNT=0, all error flags cleared.
- FSM states: IDLE, CLEAR, LOAD, DONE. All write outputs are registered; each write appears one cycle after the accepting edge.
- IDLE/DONE, START=1 -> CLEAR: clear error flags and GOTO_COUNT. DONE drops the next cycle.
- CLEAR: runs exactly DEPTH cycles, address 0..DEPTH-1.
  - WR_EN_G=WR_EN_F=1 each cycle with all data fields 0.
  - Goto RAMs are cleared to state 0 / chara 0 / next 0; failure RAM is cleared to 0.
  - After address DEPTH-1 -> LOAD. IN_READY=0 throughout.
- LOAD: IN_READY=1. An entry is transferred when IN_VALID&&IN_READY on a rising edge.
  - Goto entry: written at WR_ADDR_G=GOTO_COUNT, then GOTO_COUNT increments. If GOTO_COUNT==DEPTH, the entry is dropped, ERR_FULL=1, and no write is issued.
  - Failure entry: written at WR_ADDR_F=IN_CUR_STATE-1 with WR_FAIL_STATE=IN_NEXT_STATE. IN_CUR_STATE==0 or >DEPTH: dropped, ERR_STATE=1. A later failure entry for the same state overwrites the earlier one.
  - COMMIT=1 -> DONE. If COMMIT coincides with a transfer, the entry is written first; both happen on the same edge.
  - The cycle after COMMIT, IN_READY=0.
- DONE: DONE=1, IN_READY=0, GOTO_COUNT held, no writes.
- START in CLEAR or LOAD: restarts CLEAR at address 0. The session is abandoned, counts and flags are cleared, and no DONE is produced.
- COMMIT outside LOAD and IN_VALID outside LOAD: ignored.
- Write strobes never assert in IDLE or DONE.

Optional Feature:
AHO_TW_DUP_CHECK_EN.
- Defined: a shadow array of {cur_state, chara} for written goto entries is compared against each incoming goto entry. On a match, the entry is dropped and ERR_DUP=1; no write occurs and GOTO_COUNT does not increment. The shadow is invalidated in CLEAR.
- Undefined: no shadow logic, ERR_DUP tied 0, duplicates are written as normal entries.

Test Plan:
- Reset then START -> BUSY=1 for DEPTH+1 cycles (the CLEAR cycles plus the first LOAD cycle); 32 cycles of WR_EN_G/WR_EN_F at addresses 0..31 with data 0; then IN_READY=1.
- LOAD goto (0,'1',1), (1,'2',2), (0,'3',3), then COMMIT -> the three writes land at WR_ADDR_G 0, 1, 2 with the matching fields; GOTO_COUNT=3; DONE=1; IN_READY=0.
- Failure entries (5->2), (5->0), (0->4), (33->1) -> WR_ADDR_F=4 written with 2 then 0; the last two are dropped, ERR_STATE=1, no WR_EN_F for them.
- Send 33 goto entries -> 32 writes at addresses 0..31; the 33rd is dropped; ERR_FULL=1; GOTO_COUNT=32.
- IN_VALID with COMMIT on the same edge -> the entry is written and the next state is DONE. START pulsed mid-LOAD after 5 entries -> CLEAR restarts at address 0, GOTO_COUNT=0, flags clear.
- With AHO_TW_DUP_CHECK_EN: goto (2,'4',5) sent twice -> one write, ERR_DUP=1, GOTO_COUNT=1. Without the macro -> two writes, ERR_DUP=0.
